// File: rtl/hvac_ctrl.sv
// Clocked HVAC controller: hysteresis, minimum run time, post-run lockout and banded fan speed.
// Optional macro HVAC_CTRL_FANRUN_EN keeps the fan at low speed throughout LOCKOUT.
module hvac_ctrl #(
    parameter int TEMP_W    = 8,
    parameter int HYST      = 1,
    parameter int LOW_BAND  = 5,
    parameter int HIGH_BAND = 10,
    parameter int MIN_ON    = 8,
    parameter int MIN_OFF   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] dtemp,
    input  logic [TEMP_W-1:0] atemp,
    output logic              heat,
    output logic              cool,
    output logic              idle,
    output logic              lockout,
    output logic [1:0]        speed
);

    localparam int TMAX    = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
    localparam int TIMER_W = $clog2(TMAX + 1);

    localparam logic [TEMP_W:0]    HYST_V  = (TEMP_W+1)'(HYST);
    localparam logic [TEMP_W:0]    LOW_V   = (TEMP_W+1)'(LOW_BAND);
    localparam logic [TEMP_W:0]    HIGH_V  = (TEMP_W+1)'(HIGH_BAND);
    localparam logic [TIMER_W-1:0] ON_V    = TIMER_W'(MIN_ON);
    localparam logic [TIMER_W-1:0] OFF_V   = TIMER_W'(MIN_OFF);
    localparam logic [TIMER_W-1:0] ONE_V   = TIMER_W'(1);

`ifdef HVAC_CTRL_FANRUN_EN
    localparam logic [1:0] LOCK_SPEED = 2'b01;
`else
    localparam logic [1:0] LOCK_SPEED = 2'b00;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HEAT    = 2'b01,
        ST_COOL    = 2'b10,
        ST_LOCKOUT = 2'b11
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_nx_s;
    logic [TIMER_W-1:0] timer_dec_s;
    logic [1:0]         speed_r;
    logic [1:0]         speed_nx_s;
    logic               heat_r;
    logic               cool_r;
    logic               idle_r;
    logic               lockout_r;

    logic [TEMP_W:0]    diff_s;
    logic [TEMP_W:0]    mag_s;
    logic               heat_req_s;
    logic               cool_req_s;
    logic               heat_ok_s;
    logic               cool_ok_s;
    logic               run_done_s;

    function automatic logic [1:0] band_speed(input logic [TEMP_W:0] mag);
        if (mag <= LOW_V) begin
            band_speed = 2'b01;
        end else if (mag <= HIGH_V) begin
            band_speed = 2'b10;
        end else begin
            band_speed = 2'b11;
        end
    endfunction

    // Magnitude of the setpoint error in one extra bit so the full operand range never wraps
    always_comb begin
        diff_s      = {1'b0, dtemp} - {1'b0, atemp};
        mag_s       = diff_s[TEMP_W] ? ((TEMP_W+1)'(0) - diff_s) : diff_s;
        heat_req_s  = (atemp < dtemp) && (mag_s > HYST_V);
        cool_req_s  = (atemp > dtemp) && (mag_s > HYST_V);
        heat_ok_s   = mode[0];
        cool_ok_s   = mode[1];
        timer_dec_s = (timer_r == '0) ? '0 : (timer_r - ONE_V);
        // Timer reaching zero on this edge permits exit, giving a dwell of exactly MIN_ON clocks
        run_done_s  = (timer_r <= ONE_V);
    end

    // Next-state, timer and fan speed selection
    always_comb begin
        state_nx_s = state_r;
        timer_nx_s = timer_r;
        speed_nx_s = speed_r;
        case (state_r)
            ST_IDLE: begin
                timer_nx_s = '0;
                speed_nx_s = 2'b00;
                if (sample_valid && en && heat_req_s && heat_ok_s) begin
                    state_nx_s = ST_HEAT;
                    timer_nx_s = ON_V;
                    speed_nx_s = band_speed(mag_s);
                end else if (sample_valid && en && cool_req_s && cool_ok_s) begin
                    state_nx_s = ST_COOL;
                    timer_nx_s = ON_V;
                    speed_nx_s = band_speed(mag_s);
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HEAT: begin
                timer_nx_s = timer_dec_s;
                if (!en || !heat_ok_s) begin
                    state_nx_s = ST_LOCKOUT;
                    timer_nx_s = OFF_V;
                    speed_nx_s = LOCK_SPEED;
                end else if (sample_valid && (atemp >= dtemp) && run_done_s) begin
                    state_nx_s = ST_LOCKOUT;
                    timer_nx_s = OFF_V;
                    speed_nx_s = LOCK_SPEED;
                end else if (sample_valid) begin
                    speed_nx_s = band_speed(mag_s);
                end else begin
                    speed_nx_s = speed_r;
                end
            end
            ST_COOL: begin
                timer_nx_s = timer_dec_s;
                if (!en || !cool_ok_s) begin
                    state_nx_s = ST_LOCKOUT;
                    timer_nx_s = OFF_V;
                    speed_nx_s = LOCK_SPEED;
                end else if (sample_valid && (atemp <= dtemp) && run_done_s) begin
                    state_nx_s = ST_LOCKOUT;
                    timer_nx_s = OFF_V;
                    speed_nx_s = LOCK_SPEED;
                end else if (sample_valid) begin
                    speed_nx_s = band_speed(mag_s);
                end else begin
                    speed_nx_s = speed_r;
                end
            end
            ST_LOCKOUT: begin
                speed_nx_s = LOCK_SPEED;
                if (timer_r <= ONE_V) begin
                    state_nx_s = ST_IDLE;
                    timer_nx_s = '0;
                    speed_nx_s = 2'b00;
                end else begin
                    timer_nx_s = timer_dec_s;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                timer_nx_s = '0;
                speed_nx_s = 2'b00;
            end
        endcase
    end

    // State, timer and registered one-hot outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= '0;
            speed_r   <= 2'b00;
            heat_r    <= 1'b0;
            cool_r    <= 1'b0;
            idle_r    <= 1'b1;
            lockout_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            timer_r   <= timer_nx_s;
            speed_r   <= speed_nx_s;
            heat_r    <= (state_nx_s == ST_HEAT);
            cool_r    <= (state_nx_s == ST_COOL);
            idle_r    <= (state_nx_s == ST_IDLE);
            lockout_r <= (state_nx_s == ST_LOCKOUT);
        end
    end

    assign heat    = heat_r;
    assign cool    = cool_r;
    assign idle    = idle_r;
    assign lockout = lockout_r;
    assign speed   = speed_r;

endmodule

// File: tb/tb_hvac_ctrl.sv
// Directed testbench for hvac_ctrl with default parameters (MIN_ON=8, MIN_OFF=4).
// Expected LOCKOUT fan speed follows HVAC_CTRL_FANRUN_EN.
module tb_hvac_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sample_valid;
    logic [7:0] dtemp;
    logic [7:0] atemp;
    logic       heat;
    logic       cool;
    logic       idle;
    logic       lockout;
    logic [1:0] speed;

    int checks;
    int errors;

`ifdef HVAC_CTRL_FANRUN_EN
    localparam logic [1:0] LSPD = 2'b01;
`else
    localparam logic [1:0] LSPD = 2'b00;
`endif

    // {heat, cool, idle, lockout, speed}
    localparam logic [5:0] IDLE_O = 6'b001000;
    localparam logic [5:0] LOCK_O = {4'b0001, LSPD};

    logic [5:0] obs;
    assign obs = {heat, cool, idle, lockout, speed};

    hvac_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .sample_valid (sample_valid),
        .dtemp        (dtemp),
        .atemp        (atemp),
        .heat         (heat),
        .cool         (cool),
        .idle         (idle),
        .lockout      (lockout),
        .speed        (speed)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL reset_state obs=%b exp=%b", obs, IDLE_O);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL reset_release obs=%b exp=%b", obs, IDLE_O);
        end
    endtask

    task automatic test_no_demand();
        en = 1'b1; mode = 2'b11; dtemp = 8'd26; atemp = 8'd26; sample_valid = 1'b1;
        step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL equal_temps obs=%b exp=%b", obs, IDLE_O);
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_heat_run();
        dtemp = 8'd26; atemp = 8'd20; sample_valid = 1'b1;
        step();
        checks++;
        if (obs !== 6'b100010) begin
            errors++;
            $display("FAIL heat_entry obs=%b exp=%b", obs, 6'b100010);
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== 6'b100010) begin
                errors++;
                $display("FAIL heat_hold cyc=%0d obs=%b exp=%b", i + 2, obs, 6'b100010);
            end
        end
        // Satisfied samples from run cycle 3 on; exit only after MIN_ON clocks
        atemp = 8'd26; sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== 6'b100001) begin
                errors++;
                $display("FAIL heat_min_on cyc=%0d obs=%b exp=%b", i + 4, obs, 6'b100001);
            end
        end
        step();
        checks++;
        if (obs !== LOCK_O) begin
            errors++;
            $display("FAIL heat_exit obs=%b exp=%b", obs, LOCK_O);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== LOCK_O) begin
                errors++;
                $display("FAIL lockout_len cyc=%0d obs=%b exp=%b", i + 2, obs, LOCK_O);
            end
        end
        step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL lockout_to_idle obs=%b exp=%b", obs, IDLE_O);
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_cool_hyst();
        en = 1'b1; mode = 2'b11; dtemp = 8'd26; atemp = 8'd27; sample_valid = 1'b1;
        step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL cool_hyst_band obs=%b exp=%b", obs, IDLE_O);
        end
        atemp = 8'd28;
        step();
        checks++;
        if (obs !== 6'b010001) begin
            errors++;
            $display("FAIL cool_entry obs=%b exp=%b", obs, 6'b010001);
        end
        atemp = 8'd40;
        step();
        checks++;
        if (obs !== 6'b010011) begin
            errors++;
            $display("FAIL cool_speed_high obs=%b exp=%b", obs, 6'b010011);
        end
        sample_valid = 1'b0; en = 1'b0;
        step();
        checks++;
        if (obs !== LOCK_O) begin
            errors++;
            $display("FAIL cool_forced_en obs=%b exp=%b", obs, LOCK_O);
        end
        repeat (3) step();
        step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL cool_lock_idle obs=%b exp=%b", obs, IDLE_O);
        end
        en = 1'b1;
    endtask

    task automatic test_mode_lockout();
        mode = 2'b11; dtemp = 8'd26; atemp = 8'd20; sample_valid = 1'b1;
        step();
        checks++;
        if (obs !== 6'b100010) begin
            errors++;
            $display("FAIL mode_heat_entry obs=%b exp=%b", obs, 6'b100010);
        end
        sample_valid = 1'b0; mode = 2'b10;
        step();
        checks++;
        if (obs !== LOCK_O) begin
            errors++;
            $display("FAIL heat_forced_mode obs=%b exp=%b", obs, LOCK_O);
        end
        // Demand samples during LOCKOUT are ignored
        mode = 2'b11; atemp = 8'd10; sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== LOCK_O) begin
                errors++;
                $display("FAIL lockout_ignore cyc=%0d obs=%b exp=%b", i + 2, obs, LOCK_O);
            end
        end
        step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL lockout_release obs=%b exp=%b", obs, IDLE_O);
        end
        step();
        checks++;
        if (obs !== 6'b100011) begin
            errors++;
            $display("FAIL idle_resample obs=%b exp=%b", obs, 6'b100011);
        end
        sample_valid = 1'b0; en = 1'b0;
        step();
        checks++;
        if (obs !== LOCK_O) begin
            errors++;
            $display("FAIL heat_forced_en obs=%b exp=%b", obs, LOCK_O);
        end
        repeat (4) step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL mode_lock_idle obs=%b exp=%b", obs, IDLE_O);
        end
        en = 1'b1;
    endtask

    task automatic test_en_mode_block();
        en = 1'b0; mode = 2'b11; dtemp = 8'd26; atemp = 8'd0; sample_valid = 1'b1;
        repeat (2) step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL en_off_idle obs=%b exp=%b", obs, IDLE_O);
        end
        en = 1'b1; mode = 2'b10;
        step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL cool_only_blocks_heat obs=%b exp=%b", obs, IDLE_O);
        end
        mode = 2'b01; dtemp = 8'd20; atemp = 8'd30;
        step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL heat_only_blocks_cool obs=%b exp=%b", obs, IDLE_O);
        end
        mode = 2'b00; dtemp = 8'd30; atemp = 8'd20;
        step();
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL mode_off_idle obs=%b exp=%b", obs, IDLE_O);
        end
        sample_valid = 1'b0; mode = 2'b11;
    endtask

    task automatic test_extremes_reset();
        en = 1'b1; mode = 2'b01; dtemp = 8'd255; atemp = 8'd0; sample_valid = 1'b1;
        step();
        checks++;
        if (obs !== 6'b100011) begin
            errors++;
            $display("FAIL extreme_heat obs=%b exp=%b", obs, 6'b100011);
        end
        sample_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL async_reset_midrun obs=%b exp=%b", obs, IDLE_O);
        end
        step();
        rst = 1'b0;
        mode = 2'b10; dtemp = 8'd0; atemp = 8'd255; sample_valid = 1'b1;
        step();
        checks++;
        if (obs !== 6'b010011) begin
            errors++;
            $display("FAIL extreme_cool_no_lock obs=%b exp=%b", obs, 6'b010011);
        end
        sample_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE_O) begin
            errors++;
            $display("FAIL async_reset_cool obs=%b exp=%b", obs, IDLE_O);
        end
        step();
        rst = 1'b0;
    endtask

    // Test sequence
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en = 1'b0;
        mode = 2'b00;
        sample_valid = 1'b0;
        dtemp = 8'd0;
        atemp = 8'd0;
        test_reset();
        test_no_demand();
        test_heat_run();
        test_cool_hyst();
        test_mode_lockout();
        test_en_mode_block();
        test_extremes_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
